div_seq: RTL and testbench

Parametrised sequential radix-2 restoring divider with valid/ready handshakes on operands and results. It is the general-purpose successor of the fixed-sequence divider used in the arithmetic datapath. It adds:
- handshaked operand and result transfer with back-pressure;
- divide-by-zero detection with early completion;
- optional two's-complement signed division with overflow reporting.

It computes one quotient bit per cycle.

---
 rtl/div_seq_if.sv | 24 ++
 rtl/div_seq.sv | 141 ++++++++++++++
 tb/tb_div_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Operand/result handshake bundle for div_seq: valid/ready on operands, valid/ready on results.
interface div_seq_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             signed_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;
    logic             ovf;

    modport master (
        output in_valid, dividend, divisor, signed_op, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, signed_op, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf
    );
endinterface

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN to build two's-complement signed division (signed_op) with overflow reporting.
module div_seq #(
    parameter int WIDTH = 16
) (
    input logic      clock,
    input logic      reset,
    div_seq_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // CALC  | WIDTH shift/subtract iterations
    // FIX   | sign correction and result load
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dmag;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic is_ovf;
    logic neg_q;
    logic neg_r;
    logic ovf_flag;

    always_comb begin
        a_neg  = bus.signed_op & bus.dividend[WIDTH-1];
        b_neg  = bus.signed_op & bus.divisor[WIDTH-1];
        a_mag  = a_neg ? -bus.dividend : bus.dividend;
        b_mag  = b_neg ? -bus.divisor : bus.divisor;
        // MIN / -1: magnitude path yields MIN with zero remainder, only the flag is extra
        is_ovf = bus.signed_op && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);
    end

    always_comb begin
        q_fix = neg_q ? -dq : dq;
        r_fix = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
`else
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        q_fix = dq;
        r_fix = acc[WIDTH-1:0];
    end
`endif

    always_comb begin
        shifted = {acc[WIDTH-1:0], dq[WIDTH-1]};
        trial   = shifted - {1'b0, dmag};
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            acc           <= '0;
            dq            <= '0;
            dmag          <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.dbz       <= 1'b0;
            bus.ovf       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            ovf_flag      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.divisor == '0) begin
                            bus.quotient  <= '1;
                            bus.remainder <= bus.dividend;
                            bus.dbz       <= 1'b1;
                            bus.ovf       <= 1'b0;
                            state         <= DONE;
                        end else begin
                            dq    <= a_mag;
                            dmag  <= b_mag;
                            acc   <= '0;
                            count <= '0;
`ifdef DIV_SIGNED_EN
                            neg_q    <= a_neg ^ b_neg;
                            neg_r    <= a_neg;
                            ovf_flag <= is_ovf;
`endif
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // trial MSB set means the subtract went negative: restore
                    if (trial[WIDTH]) begin
                        acc <= shifted;
                        dq  <= {dq[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= trial;
                        dq  <= {dq[WIDTH-2:0], 1'b1};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) state <= FIX;
                end
                FIX: begin
                    bus.quotient  <= q_fix;
                    bus.remainder <= r_fix;
                    bus.dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
                    bus.ovf       <= ovf_flag;
`else
                    bus.ovf       <= 1'b0;
`endif
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (WIDTH=16): vector table, corner sequences, random vs arithmetic model.
module tb_div_seq;
    localparam int W = 16;
`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    div_seq_if #(.WIDTH(W)) bus ();
    div_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z, output logic o);
        longint sa, sb;
        z = 1'b0;
        o = 1'b0;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else if (SGN && s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
            o  = (a == 16'h8000) && (b == 16'hFFFF);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present operands, count cycles to out_valid, hold out_ready low for 'hold' cycles, release.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic z, output logic o, output int lat);
        int busy_err;
        busy_err = 0;
        check("in_ready_idle", bus.in_ready, 1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = s;
        bus.in_valid  = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) busy_err++;
            @(negedge clock);
            lat++;
        end
        check("busy_in_ready", busy_err, 0);
        if (!bus.out_valid) begin
            check("timeout_out_valid", bus.out_valid, 1);
            q = 'x; r = 'x; z = 'x; o = 'x;
            return;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.dbz;
        o = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (bus.quotient !== q || bus.remainder !== r || !bus.out_valid || bus.in_ready)
                busy_err++;
        end
        check("hold_stable", busy_err, 0);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("release_in_ready", bus.in_ready, 1);
        check("release_out_valid", bus.out_valid, 0);
    endtask

    vec_t vecs[10];
    logic [15:0] q, r, eq, er, pq, pr;
    logic z, o, ez, eo;
    int lat, err;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.signed_op = 1'b0;

        vecs[0] = '{16'd100,  16'd7,      1'b0, 16'd14,   16'd2,    1'b0, 1'b0};
        vecs[1] = '{16'd5,    16'd0,      1'b0, 16'hFFFF, 16'd5,    1'b1, 1'b0};
        vecs[2] = '{16'hFFF9, 16'h0002,   1'b1, SGN ? 16'hFFFD : 16'h7FFC, SGN ? 16'hFFFF : 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'hFFF9, 16'h0002,   1'b0, 16'h7FFC, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'hFFFF,   1'b1, SGN ? 16'h8000 : 16'h0000, SGN ? 16'h0000 : 16'h8000, 1'b0, SGN};
        vecs[5] = '{16'hFFFF, 16'h0010,   1'b0, 16'h0FFF, 16'h000F, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0001,   1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'h0001, 16'hFFFF,   1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[8] = '{16'h0007, 16'hFFFE,   1'b1, SGN ? 16'hFFFD : 16'h0000, SGN ? 16'h0001 : 16'h0007, 1'b0, 1'b0};
        vecs[9] = '{16'h8000, 16'h0000,   1'b1, 16'hFFFF, 16'h8000, 1'b1, 1'b0};

        repeat (2) @(negedge clock);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.dbz, 0);
        check("rst_ovf", bus.ovf, 0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].s, 1, q, r, z, o, lat);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
            check($sformatf("vec%0d_ovf", i), o, vecs[i].o);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].z ? 1 : 18);
        end

        // Back-pressure: result held 5 cycles while in_valid pulses are ignored.
        bus.dividend = 16'hFFFF; bus.divisor = 16'h0010; bus.signed_op = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("bp_out_valid", bus.out_valid, 1);
        err = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 16'd9;
            bus.divisor  = 16'd0;
            @(negedge clock);
            if (bus.quotient !== 16'h0FFF || bus.remainder !== 16'h000F || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b1 || bus.dbz !== 1'b0)
                err++;
        end
        bus.in_valid = 1'b0;
        check("bp_stable", err, 0);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", bus.in_ready, 1);
        repeat (3) @(negedge clock);
        check("bp_no_phantom", bus.out_valid, 0);

        // Reset at CALC iteration 8 discards the divide.
        bus.dividend = 16'hFFFF; bus.divisor = 16'h0010;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        check("midrst_dbz_ovf", {bus.dbz, bus.ovf}, 0);
        reset = 1'b0;
        err = 0;
        repeat (25) begin
            @(negedge clock);
            if (bus.out_valid || !bus.in_ready) err++;
        end
        check("midrst_silent", err, 0);
        do_div(16'd9, 16'd3, 1'b0, 0, q, r, z, o, lat);
        check("post_rst_quotient", q, 3);
        check("post_rst_remainder", r, 0);

        // Random operands against the arithmetic model.
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a, b;
            logic s;
            a = (($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom));
            case ($urandom_range(0, 7))
                0: b = 16'd0;
                1: b = 16'($urandom_range(1, 15));
                2: b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er, ez, eo);
            do_div(a, b, s, $urandom_range(0, 3), q, r, z, o, lat);
            check($sformatf("rand%0d_q a=%h b=%h s=%0d", n, a, b, s), q, eq);
            check($sformatf("rand%0d_r", n), r, er);
            check($sformatf("rand%0d_flags", n), {z, o}, {ez, eo});
            check($sformatf("rand%0d_lat", n), lat, ez ? 1 : 18);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
